stack_engine: RTL and testbench
===============================

STACK_ENGINE -- requirements
Module: stack_engine

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits (>=4).
REQ-002 Parameter DEPTH, default 32, maximum stack entries (>=4, power of two not required).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  opcode/data present this cycle.
REQ-006 op_ready  output  1  engine accepts an op this cycle.
REQ-007 opcode  input  3  000 NOP, 001 PUSH, 010 POP, 011 DUP, 100 SWAP, 101 ADD, 110 SUB, 111 AND.
REQ-008 getin  input  WIDTH  operand for PUSH.
REQ-009 err_clr  input  1  single-cycle pulse leaving ERROR.
REQ-010 top_of_stack  output  WIDTH  registered TOS; 0 when depth==0.
REQ-011 second_of_stack  output  WIDTH  registered NOS; 0 when depth<2.
REQ-012 depth  output  $clog2(DEPTH+1)  current entry count.
REQ-013 err_code  output  2  00 none, 01 overflow, 10 underflow, 11 illegal op; sticky.

Function
REQ-014 An op is accepted on a rising edge where op_valid && op_ready; results visible the following cycle (latency 1, throughput 1/cycle).
REQ-015 States: RUN (op_ready=1) and ERROR (op_ready=0); RUN->ERROR on any faulting accepted op; ERROR->RUN on err_clr, which also sets err_code to 00.
REQ-016 TOS/NOS held in registers; entries 3..DEPTH held in spill RAM indexed by depth-3; RAM read is combinational.
REQ-017 PUSH: NOS<=TOS, TOS<=getin, old NOS spilled to RAM when depth>=2, depth+1; overflow if depth==DEPTH.
REQ-018 POP: TOS<=NOS, NOS<=RAM top (0 if depth<=2), depth-1; underflow if depth==0.
REQ-019 DUP: NOS<=TOS, spill as PUSH, depth+1; underflow if depth==0, overflow if depth==DEPTH (underflow takes priority).
REQ-020 SWAP: exchange TOS/NOS, depth unchanged; underflow if depth<2.
REQ-021 ADD/SUB/AND: TOS<=NOS op TOS (SUB = NOS-TOS), modulo 2^WIDTH, carry discarded; NOS refilled as POP; depth-1; underflow if depth<2.
REQ-022 Faulting op leaves TOS, NOS, RAM, depth unchanged.
REQ-023 NOP: no state change, never faults.
REQ-024 err_clr in RUN is ignored; op_valid in ERROR is ignored (no state change).
REQ-025 Stack contents preserved across ERROR.

Reset
REQ-026 On reset_n low, asynchronously: state=RUN, depth=0, top_of_stack=0, second_of_stack=0, err_code=00; RAM contents undefined and never observable.
REQ-027 Reset asserted mid-operation discards the in-flight op; first op accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro STACK_ARITH_EN defined: ADD, SUB, AND implemented per REQ-021.
REQ-029 Macro STACK_ARITH_EN undefined: opcodes 101/110/111 are illegal -> err_code 11, ERROR, no state change; no adder/logic inferred.

Structure
REQ-030 Package stack_pkg holds opcode constants, err_code constants and the RUN/ERROR state encoding.
REQ-031 Sub-module stack_spill_ram (parameters WIDTH, DEPTH-2; one write port, one combinational read port) holds spill entries.

Verification
REQ-032 Reset, PUSH 5, PUSH 7 -> top_of_stack=7, second_of_stack=5, depth=2.
REQ-033 PUSH 1..DEPTH, then PUSH 99 -> err_code=01, op_ready=0, depth=DEPTH, TOS=DEPTH; err_clr -> op_ready=1, err_code=00; DEPTH POPs return DEPTH..1 in order.
REQ-034 From empty, POP -> err_code=10, depth=0, TOS=0; SWAP with depth=1 -> err_code=10.
REQ-035 With STACK_ARITH_EN: PUSH 3, PUSH 5, SUB -> TOS=0xFFFE (WIDTH=16), depth=1; PUSH 0xFFFF, PUSH 2, ADD -> TOS=1. Without: ADD -> err_code=11, stack unchanged.
REQ-036 Back-to-back PUSH A, DUP, SWAP, POP every cycle with op_valid held high -> op_ready stays 1, final TOS=A, depth=1.
REQ-037 Assert reset_n low between clock edges with depth=4 -> outputs zero immediately, depth=0; next PUSH 9 -> TOS=9, NOS=0.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared definitions for the stack engine: opcodes, error codes, control state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: opcode_e (3-bit opcode map), err_e (sticky error codes),
// state_e (RUN/ERROR control state), addr_bits() helper for RAM address width.
package stack_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_DUP  = 3'b011,
    OP_SWAP = 3'b100,
    OP_ADD  = 3'b101,
    OP_SUB  = 3'b110,
    OP_AND  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'b00,
    ERR_OVERFLOW  = 2'b01,
    ERR_UNDERFLOW = 2'b10,
    ERR_ILLEGAL   = 2'b11
  } err_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_ERROR = 1'b1
  } state_e;

  // Address width for an n-entry memory; never less than one bit.
  function automatic int addr_bits(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stack_spill_ram.sv
// Spill storage for stack entries below TOS/NOS; one write port, one async read port.
// Latency: write lands on the rising edge, read is combinational.
// Backpressure: none; the caller guarantees addresses are in range when used.
//
// Ports:
//   clk_i     clock
//   we_i      write enable
//   waddr_i   write address
//   wdata_i   write data
//   raddr_i   read address
//   rdata_o   read data (combinational)
module stack_spill_ram
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 30,
  localparam int AW = addr_bits(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  // No reset: contents are only ever read back after having been written.
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_engine.sv
// Hardware operand stack: TOS/NOS in registers, deeper entries spilled to RAM.
// Latency: 1 cycle per op, 1 op/cycle throughput.
// Backpressure: op_ready drops in ERROR until an err_clr pulse; ops offered then are ignored.
//
// Ports:
//   CLK, reset_n        clock, asynchronous active-low reset
//   op_valid/op_ready   op handshake; opcode + getin (PUSH operand) qualify it
//   err_clr             leaves ERROR and clears err_code
//   top_of_stack        registered TOS (0 when empty)
//   second_of_stack     registered NOS (0 when fewer than two entries)
//   depth               entry count
//   err_code            sticky error: 00 none, 01 overflow, 10 underflow, 11 illegal
//
// Build option: define STACK_ARITH_EN to implement ADD/SUB/AND; otherwise
// those opcodes fault as illegal and no ALU is built.
module stack_engine
  import stack_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32
) (
  input  logic                         CLK,
  input  logic                         reset_n,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [2:0]                   opcode,
  input  logic [WIDTH-1:0]             getin,
  input  logic                         err_clr,
  output logic [WIDTH-1:0]             top_of_stack,
  output logic [WIDTH-1:0]             second_of_stack,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [1:0]                   err_code
);

  localparam int DW    = $clog2(DEPTH + 1);
  localparam int RAM_N = DEPTH - 2;
  localparam int AW    = addr_bits(RAM_N);
  localparam logic [DW-1:0] D_FULL = DW'(DEPTH);

  state_e           state_q, state_d;
  err_e             err_q, err_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;

  logic             ram_we;
  logic [AW-1:0]    ram_waddr;
  logic [AW-1:0]    ram_raddr;
  logic [WIDTH-1:0] ram_rdata;
  logic [WIDTH-1:0] refill;

  logic             fault;
  err_e             fault_code;

  // The entry under NOS lives at RAM[depth-3]; a push that keeps NOS
  // occupied writes the old NOS one slot above that, at RAM[depth-2].
  assign ram_raddr = AW'(depth_q - DW'(3));
  assign ram_waddr = AW'(depth_q - DW'(2));
  assign refill    = (depth_q >= DW'(3)) ? ram_rdata : '0;

  stack_spill_ram #(
    .WIDTH (WIDTH),
    .DEPTH (RAM_N)
  ) u_spill (
    .clk_i   (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (nos_q),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

`ifdef STACK_ARITH_EN
  logic [WIDTH-1:0] alu_res;

  // NOS is the left operand, so SUB yields NOS - TOS; carries wrap away.
  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = nos_q + tos_q;
      OP_SUB:  alu_res = nos_q - tos_q;
      OP_AND:  alu_res = nos_q & tos_q;
      default: alu_res = '0;
    endcase
  end
`endif

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    tos_d      = tos_q;
    nos_d      = nos_q;
    depth_d    = depth_q;
    ram_we     = 1'b0;
    fault      = 1'b0;
    fault_code = ERR_NONE;

    if (state_q == ST_ERROR) begin
      if (err_clr) begin
        state_d = ST_RUN;
        err_d   = ERR_NONE;
      end
    end else if (op_valid) begin
      // Every branch that updates state does so only when no fault is raised,
      // so a faulting op leaves the stack untouched.
      case (opcode)
        OP_PUSH: begin
          if (depth_q == D_FULL) begin
            fault      = 1'b1;
            fault_code = ERR_OVERFLOW;
          end else begin
            tos_d   = getin;
            nos_d   = tos_q;
            depth_d = depth_q + DW'(1);
            ram_we  = (depth_q >= DW'(2));
          end
        end
        OP_POP: begin
          if (depth_q == '0) begin
            fault      = 1'b1;
            fault_code = ERR_UNDERFLOW;
          end else begin
            tos_d   = nos_q;
            nos_d   = refill;
            depth_d = depth_q - DW'(1);
          end
        end
        OP_DUP: begin
          if (depth_q == '0) begin
            fault      = 1'b1;
            fault_code = ERR_UNDERFLOW;
          end else if (depth_q == D_FULL) begin
            fault      = 1'b1;
            fault_code = ERR_OVERFLOW;
          end else begin
            nos_d   = tos_q;
            depth_d = depth_q + DW'(1);
            ram_we  = (depth_q >= DW'(2));
          end
        end
        OP_SWAP: begin
          if (depth_q < DW'(2)) begin
            fault      = 1'b1;
            fault_code = ERR_UNDERFLOW;
          end else begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
        end
`ifdef STACK_ARITH_EN
        OP_ADD, OP_SUB, OP_AND: begin
          if (depth_q < DW'(2)) begin
            fault      = 1'b1;
            fault_code = ERR_UNDERFLOW;
          end else begin
            tos_d   = alu_res;
            nos_d   = refill;
            depth_d = depth_q - DW'(1);
          end
        end
`else
        OP_ADD, OP_SUB, OP_AND: begin
          fault      = 1'b1;
          fault_code = ERR_ILLEGAL;
        end
`endif
        default: ; // NOP
      endcase

      if (fault) begin
        state_d = ST_ERROR;
        err_d   = fault_code;
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      err_q   <= ERR_NONE;
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
    end
  end

  assign op_ready        = (state_q == ST_RUN);
  assign top_of_stack    = tos_q;
  assign second_of_stack = nos_q;
  assign depth           = depth_q;
  assign err_code        = err_q;

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine: directed scenarios plus random ops,
// scored against a queue-based stack model; a monitor pops expected snapshots
// every cycle and compares them against the DUT outputs.
module tb_stack_engine;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             reset_n = 1'b0;
  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [2:0]       opcode = 3'd0;
  logic [WIDTH-1:0] getin = '0;
  logic             err_clr = 1'b0;
  logic [WIDTH-1:0] top_of_stack;
  logic [WIDTH-1:0] second_of_stack;
  logic [DW-1:0]    depth;
  logic [1:0]       err_code;

  stack_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK             (CLK),
    .reset_n         (reset_n),
    .op_valid        (op_valid),
    .op_ready        (op_ready),
    .opcode          (opcode),
    .getin           (getin),
    .err_clr         (err_clr),
    .top_of_stack    (top_of_stack),
    .second_of_stack (second_of_stack),
    .depth           (depth),
    .err_code        (err_code)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] tos;
    logic [WIDTH-1:0] nos;
    int               dep;
    logic [1:0]       err;
    logic             rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: the stack is a plain queue, last element is the top.
  logic [WIDTH-1:0] stk[$];
  logic [1:0]       m_err = 2'd0;
  bit               m_halted = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, req, $time);
    end
  endtask

  function automatic exp_t snap();
    exp_t s;
    int n = stk.size();
    s.tos = (n > 0) ? stk[n-1] : '0;
    s.nos = (n > 1) ? stk[n-2] : '0;
    s.dep = n;
    s.err = m_err;
    s.rdy = !m_halted;
    return s;
  endfunction

  task automatic model_op(bit v, logic [2:0] op, logic [WIDTH-1:0] d, bit clr);
    int n;
    logic [1:0] f;
    logic [WIDTH-1:0] a, b, t;
    if (m_halted) begin
      if (clr) begin
        m_halted = 1'b0;
        m_err    = 2'd0;
      end
      return;
    end
    if (!v) return;
    n = stk.size();
    f = 2'd0;
    case (op)
      3'd1: if (n == DEPTH) f = 2'd1; else stk.push_back(d);
      3'd2: if (n == 0) f = 2'd2; else void'(stk.pop_back());
      3'd3: begin
        if (n == 0) f = 2'd2;
        else if (n == DEPTH) f = 2'd1;
        else begin
          t = stk[n-1];
          stk.push_back(t);
        end
      end
      3'd4: begin
        if (n < 2) f = 2'd2;
        else begin
          t = stk[n-1];
          stk[n-1] = stk[n-2];
          stk[n-2] = t;
        end
      end
      3'd5, 3'd6, 3'd7: begin
`ifdef STACK_ARITH_EN
        if (n < 2) f = 2'd2;
        else begin
          b = stk.pop_back();
          a = stk.pop_back();
          if (op == 3'd5) t = a + b;
          else if (op == 3'd6) t = a - b;
          else t = a & b;
          stk.push_back(t);
        end
`else
        a = '0;
        b = '0;
        f = 2'd3;
`endif
      end
      default: ;
    endcase
    if (f != 2'd0) begin
      m_err    = f;
      m_halted = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic step(bit v, logic [2:0] op, logic [WIDTH-1:0] d, bit clr);
    @(negedge CLK);
    op_valid = v;
    opcode   = op;
    getin    = d;
    err_clr  = clr;
    model_op(v, op, d, clr);
    exp_q.push_back(snap());
  endtask

  task automatic idle();
    step(1'b0, 3'd0, '0, 1'b0);
  endtask

  task automatic expect_now(string nm, int tos, int nos, int dep, int err, int rdy);
    chk({nm, "_tos"},   32'(top_of_stack),    32'(tos));
    chk({nm, "_nos"},   32'(second_of_stack), 32'(nos));
    chk({nm, "_depth"}, 32'(depth),           32'(dep));
    chk({nm, "_err"},   32'(err_code),        32'(err));
    chk({nm, "_rdy"},   32'(op_ready),        32'(rdy));
  endtask

  // Assert reset between edges (optionally with a PUSH in flight), check the
  // outputs clear immediately, hold for two edges, release between edges.
  task automatic do_reset(bit inflight);
    @(negedge CLK);
    if (inflight) begin
      op_valid = 1'b1;
      opcode   = 3'd1;
      getin    = 16'h1234;
    end
    #2 reset_n = 1'b0;
    stk.delete();
    m_err    = 2'd0;
    m_halted = 1'b0;
    #1 expect_now("rst_async", 0, 0, 0, 0, 1);
    exp_q.push_back(snap());
    exp_q.push_back(snap());
    @(posedge CLK);
    @(posedge CLK);
    #3;
    op_valid = 1'b0;
    err_clr  = 1'b0;
    reset_n  = 1'b1;
  endtask

  exp_t mon_e;
  always @(posedge CLK) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("sb_tos",   32'(top_of_stack),    32'(mon_e.tos));
      chk("sb_nos",   32'(second_of_stack), 32'(mon_e.nos));
      chk("sb_depth", 32'(depth),           32'(mon_e.dep));
      chk("sb_err",   32'(err_code),        32'(mon_e.err));
      chk("sb_rdy",   32'(op_ready),        32'(mon_e.rdy));
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op;
    int r;

    // Two pushes land in TOS/NOS.
    do_reset(1'b0);
    step(1'b1, 3'd1, 16'd5, 1'b0);
    step(1'b1, 3'd1, 16'd7, 1'b0);
    idle();
    expect_now("push2", 7, 5, 2, 0, 1);

    // Back-to-back PUSH, DUP, SWAP, POP.
    do_reset(1'b0);
    step(1'b1, 3'd1, 16'hA5A5, 1'b0);
    step(1'b1, 3'd3, '0, 1'b0);
    step(1'b1, 3'd4, '0, 1'b0);
    step(1'b1, 3'd2, '0, 1'b0);
    idle();
    expect_now("b2b", 16'hA5A5, 0, 1, 0, 1);

    // Underflow cases.
    do_reset(1'b0);
    step(1'b1, 3'd2, '0, 1'b0);
    idle();
    expect_now("pop_empty", 0, 0, 0, 2, 0);
    step(1'b0, 3'd0, '0, 1'b1);
    step(1'b1, 3'd1, 16'd4, 1'b0);
    step(1'b1, 3'd4, '0, 1'b0);
    idle();
    expect_now("swap_d1", 4, 0, 1, 2, 0);
    step(1'b0, 3'd0, '0, 1'b1);

    // Fill, overflow, recover, drain in LIFO order through the spill RAM.
    do_reset(1'b0);
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 3'd1, 16'(i), 1'b0);
    step(1'b1, 3'd1, 16'd99, 1'b0);
    idle();
    expect_now("overflow", DEPTH, DEPTH - 1, DEPTH, 1, 0);
    step(1'b1, 3'd2, '0, 1'b0);
    step(1'b0, 3'd0, '0, 1'b1);
    idle();
    expect_now("clr", DEPTH, DEPTH - 1, DEPTH, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'd2, '0, 1'b0);
    idle();
    expect_now("drained", 0, 0, 0, 0, 1);

    // Arithmetic (or illegal-op handling when not built).
    do_reset(1'b0);
    step(1'b1, 3'd1, 16'd3, 1'b0);
    step(1'b1, 3'd1, 16'd5, 1'b0);
    step(1'b1, 3'd6, '0, 1'b0);
    idle();
`ifdef STACK_ARITH_EN
    expect_now("sub", 16'hFFFE, 0, 1, 0, 1);
    step(1'b1, 3'd1, 16'hFFFF, 1'b0);
    step(1'b1, 3'd1, 16'd2, 1'b0);
    step(1'b1, 3'd5, '0, 1'b0);
    idle();
    expect_now("add", 1, 16'hFFFE, 2, 0, 1);
`else
    expect_now("illegal", 5, 3, 2, 3, 0);
    step(1'b0, 3'd0, '0, 1'b1);
`endif

    // Reset mid-operation with depth 4 and a PUSH in flight.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 3'd1, 16'(20 + i), 1'b0);
    idle();
    expect_now("pre_rst", 23, 22, 4, 0, 1);
    do_reset(1'b1);
    step(1'b1, 3'd1, 16'd9, 1'b0);
    idle();
    expect_now("post_rst", 9, 0, 1, 0, 1);

    // Random traffic, including err_clr in RUN and ops offered in ERROR.
    do_reset(1'b0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset($urandom_range(0, 1) == 1);
      r = $urandom_range(0, 9);
      if (r <= 3) op = 3'd1;
      else if (r == 4) op = 3'd2;
      else if (r == 5) op = 3'd3;
      else if (r == 6) op = 3'd4;
      else if (r == 7) op = 3'd0;
      else op = 3'(5 + $urandom_range(0, 2));
      step($urandom_range(0, 9) < 8, op, 16'($urandom), $urandom_range(0, 9) < 3);
    end
    idle();
    idle();
    @(negedge CLK);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
